// File: rtl/line_raster.sv
// Bresenham line rasterizer: walks from (x0,y0) to (x1,y1) one pixel per
// accepted handshake, suppressing pixels that fall outside the framebuffer.
module line_raster #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned FB_W    = 64,
    parameter int unsigned FB_H    = 64,
    localparam int unsigned ADDR_W = $clog2(FB_W * FB_H)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               busy,
    output logic               done,
    output logic [COORD_W:0]   pix_count
);

    // Two guard bits keep err and 2*err free of overflow for any endpoints.
    localparam int unsigned EW = COORD_W + 2;

    typedef enum logic [1:0] {IDLE, INIT, STEP, DONE} state_t;

    state_t                   state_q, state_d;
    logic [COORD_W-1:0]       lx0_q, ly0_q, lx1_q, ly1_q;
    logic [COORD_W-1:0]       lx0_d, ly0_d, lx1_d, ly1_d;
    logic signed [EW-1:0]     dx_q, dy_q, err_q;
    logic signed [EW-1:0]     dx_d, dy_d, err_d;
    logic                     sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;
    logic [COORD_W-1:0]       cx_q, cy_q, cx_d, cy_d;
    logic signed [EW-1:0]     e2;
    logic                     step_x, step_y, advance;
    logic                     pix_valid_d, busy_d, done_d;
    logic [COORD_W-1:0]       pix_x_d, pix_y_d;
    logic [ADDR_W-1:0]        pix_addr_d;
    logic [COORD_W:0]         pix_count_d;

    function automatic logic in_fb(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ((COORD_W+1)'(x) < (COORD_W+1)'(FB_W)) && ((COORD_W+1)'(y) < (COORD_W+1)'(FB_H));
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            lx0_q     <= '0;
            ly0_q     <= '0;
            lx1_q     <= '0;
            ly1_q     <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
        end else begin
            state_q   <= state_d;
            lx0_q     <= lx0_d;
            ly0_q     <= ly0_d;
            lx1_q     <= lx1_d;
            ly1_q     <= ly1_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            sx_neg_q  <= sx_neg_d;
            sy_neg_q  <= sy_neg_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            pix_valid <= pix_valid_d;
            pix_x     <= pix_x_d;
            pix_y     <= pix_y_d;
            pix_addr  <= pix_addr_d;
            busy      <= busy_d;
            done      <= done_d;
            pix_count <= pix_count_d;
        end
    end

    // Next-state, Bresenham step and registered-output values
    always_comb begin
        state_d     = state_q;
        lx0_d       = lx0_q;
        ly0_d       = ly0_q;
        lx1_d       = lx1_q;
        ly1_d       = ly1_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        pix_count_d = pix_count;
        e2          = err_q <<< 1;
        step_x      = e2 > -dy_q;
        step_y      = e2 < dx_q;
        // pix_valid mirrors in-bounds in STEP, so !pix_valid means a suppressed pixel
        advance     = !pix_valid || pix_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lx0_d       = x0;
                    ly0_d       = y0;
                    lx1_d       = x1;
                    ly1_d       = y1;
                    pix_count_d = '0;
                    state_d     = INIT;
                end
            end
            INIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dx_d     = (lx1_q >= lx0_q) ? EW'(lx1_q - lx0_q) : EW'(lx0_q - lx1_q);
                    dy_d     = (ly1_q >= ly0_q) ? EW'(ly1_q - ly0_q) : EW'(ly0_q - ly1_q);
                    err_d    = dx_d - dy_d;
                    sx_neg_d = !(lx0_q < lx1_q);
                    sy_neg_d = !(ly0_q < ly1_q);
                    cx_d     = lx0_q;
                    cy_d     = ly0_q;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (advance) begin
                    if (pix_valid) begin
                        pix_count_d = pix_count + (COORD_W+1)'(1);
                    end
                    if ((cx_q == lx1_q) && (cy_q == ly1_q)) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q - (step_x ? dy_q : EW'(0)) + (step_y ? dx_q : EW'(0));
                        if (step_x) begin
                            cx_d = sx_neg_q ? cx_q - COORD_W'(1) : cx_q + COORD_W'(1);
                        end
                        if (step_y) begin
                            cy_d = sy_neg_q ? cy_q - COORD_W'(1) : cy_q + COORD_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pix_valid_d = (state_d == STEP) && in_fb(cx_d, cy_d);
        pix_x_d     = cx_d;
        pix_y_d     = cy_d;
        pix_addr_d  = ADDR_W'(cy_d) * ADDR_W'(FB_W) + ADDR_W'(cx_d);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

endmodule

// File: doc/line_raster.md
LINE_RASTER -- requirements
Module: line_raster

Interface
REQ-001 SHALL have parameter COORD_W, default 8: coordinate width in bits for x0/y0/x1/y1 and pix_x/pix_y.
REQ-002 SHALL have parameter FB_W, default 64: framebuffer width in pixels, with FB_W ≤ 2^COORD_W.
REQ-003 SHALL have parameter FB_H, default 64: framebuffer height in pixels, with FB_H ≤ 2^COORD_W.
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock
- n_rst  in  1  asynchronous active-low reset
REQ-005 SHALL have these inputs:
- start  in  1  request a line draw; accepted only in IDLE
- abort  in  1  cancel the line in progress
- x0, y0  in  COORD_W each  start point, unsigned
- x1, y1  in  COORD_W each  end point, unsigned
- pix_ready  in  1  downstream accepts the pixel
REQ-006 SHALL have these outputs:
- pix_valid  out  1  pix_x/pix_y/pix_addr hold an in-bounds pixel
- pix_x, pix_y  out  COORD_W each  pixel coordinate
- pix_addr  out  clog2(FB_W*FB_H)  pixel address = pix_y*FB_W + pix_x
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- pix_count  out  COORD_W+1  number of pixels transferred in the current or last line

Function
REQ-007 SHALL implement the FSM IDLE -> INIT -> STEP -> DONE -> IDLE with a registered state.
REQ-008 IDLE: when start=1, SHALL latch x0, y0, x1, y1, clear pix_count, and enter INIT on the next edge.
REQ-009 start in any state other than IDLE SHALL be ignored, and the latched coordinates SHALL remain unchanged.
REQ-010 INIT (one cycle) SHALL compute dx=|x1-x0|, dy=|y1-y0|, sx=+1/-1 (x0<x1), sy=+1/-1 (y0<y1), err=dx-dy, cur=(x0,y0), then enter STEP.
REQ-011 err and e2 SHALL be signed COORD_W+2 bits; no overflow is permitted for any input values.
REQ-012 STEP: in-bounds means cur_x<FB_W and cur_y<FB_H; pix_valid SHALL equal in-bounds, with pix_x/pix_y driven from cur.
REQ-013 STEP SHALL advance when (pix_valid && pix_ready) or when cur is out of bounds; an out-of-bounds pixel is suppressed, costs one cycle, and is not counted.
REQ-014 While pix_valid=1 and pix_ready=0, pix_x, pix_y, and pix_addr SHALL be held stable and pix_valid SHALL remain high.
REQ-015 Advance when cur==(x1,y1): the FSM SHALL enter DONE.
REQ-016 Advance otherwise SHALL use e2=2*err computed from the pre-update err:
- if e2>-dy: err-=dy, x+=sx
- if e2<dx: err+=dx, y+=sy
- both updates apply in the same cycle when both conditions hold.
REQ-017 pix_count SHALL increment on each pix_valid && pix_ready cycle and SHALL hold its value after DONE until the next start is accepted.
REQ-018 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; pix_valid SHALL be 0 in IDLE, INIT, and DONE.
REQ-019 Throughput SHALL be one pixel per cycle with pix_ready=1; start-to-first-pix_valid latency SHALL be 2 cycles.
REQ-020 Degenerate line (x0==x1 and y0==y1) SHALL emit exactly one pixel, then DONE.
REQ-021 abort=1 in INIT or STEP SHALL force IDLE on the next edge with no done pulse.
REQ-022 The pixel presented in an abort cycle SHALL count as not transferred, even if pix_ready=1, and pix_count SHALL not increment.
REQ-023 abort in IDLE or DONE SHALL be ignored.
REQ-024 abort SHALL take priority over start and over the handshake.

Reset
REQ-025 While n_rst=0, asynchronously: state=IDLE, and pix_valid=0, busy=0, done=0, pix_x=0, pix_y=0, pix_addr=0, pix_count=0, internal err/cur/latched coordinates=0.
REQ-026 Reset asserted mid-line SHALL discard the line; after release the block SHALL sit in IDLE until the next start.

Verification
REQ-027 Diagonal line: (0,0)->(3,3), pix_ready=1 -> pixels (0,0),(1,1),(2,2),(3,3) on consecutive cycles, done pulse the cycle after (3,3), pix_count=4.
REQ-028 X-major reverse line: (5,2)->(0,4) -> pixel sequence (5,2),(4,2),(3,3),(2,3),(1,4),(0,4), pix_count=6, pix_addr of (3,3)=195.
REQ-029 Backpressure and start-while-busy:
- stimulus: during line (0,0)->(3,3), drop pix_ready for 3 cycles at pixel 2 and pulse start while busy
- response: (1,1) held stable with valid high for 4 cycles, start ignored, sequence otherwise unchanged
REQ-030 Clipping: (60,0)->(70,0) with FB_W=64 -> pixels x=60..63 emitted, 7 suppressed cycles, done pulse, pix_count=4.
REQ-031 Abort: assert abort at the 3rd pixel of (0,0)->(7,7) -> IDLE next cycle, no done, pix_count=2; a following start is accepted normally.
REQ-032 Reset and degenerate line:
- stimulus: n_rst low mid-line, then start (9,9)->(9,9) after release
- response: all outputs 0 during reset; after release exactly one pixel (9,9), done pulse, pix_count=1
